mem_dump_tx: RTL and testbench
==============================

MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 The block SHALL have parameter BITS, default 32, SRAM word width in bits; only 32 is supported.
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of SRAM words to dump.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit; minimum 2.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-007 The block SHALL have port busy  output  1  high while a dump is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse when the dump completes.
REQ-009 The block SHALL have port sram_rd_en  output  1  SRAM read strobe.
REQ-010 The block SHALL have port sram_addr  output  $clog2(DEPTH)  SRAM word address.
REQ-011 The block SHALL have port sram_data  input  BITS  SRAM read data, valid the cycle after sram_rd_en.
REQ-012 The block SHALL have port uart_tx_pin  output  1  UART serial line, idle high.

Function
REQ-013 Line format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles, no gap between consecutive frames.
REQ-014 A dump SHALL transmit header byte 0x53 ("S"), then DEPTH words in address order 0..DEPTH-1, each as 4 bytes: bits[7:0], [15:8], [23:16], [31:24]; total 1+4*DEPTH bytes, matching the loader byte order.
REQ-015 Top-level FSM states SHALL be IDLE, HEADER, FETCH, WAIT, SEND, FINISH.
REQ-016 IDLE: start=1 SHALL move to HEADER and raise busy the next cycle; start=0 stays in IDLE.
REQ-017 HEADER: SHALL issue byte 0x53 to the serializer, then go to FETCH once it is accepted.
REQ-018 FETCH: SHALL assert sram_rd_en for exactly one cycle with sram_addr = current word index, then go to WAIT.
REQ-019 WAIT: SHALL capture sram_data into a 32-bit word register on the cycle after sram_rd_en, set byte index to 0, and go to SEND.
REQ-020 SEND: SHALL issue the byte selected by the byte index each time the serializer is free; after byte 3 is accepted, SHALL go to FETCH with word index +1, or to FINISH if the word index is DEPTH-1.
REQ-021 FINISH: SHALL wait until the last stop bit has fully elapsed, pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-022 start SHALL be ignored while busy=1, including the cycle done is pulsed.
REQ-023 The word index SHALL NOT wrap; sram_addr SHALL hold 0 while in IDLE.
REQ-024 sram_rd_en SHALL be high exactly DEPTH cycles per dump and never high outside FETCH.
REQ-025 Serializer handshake: tx_start accepted only when tx_busy=0; tx_start high at cycle N SHALL drive the start bit from cycle N+1, with tx_busy high from N+1 to the last cycle of the stop bit.
REQ-026 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit counter SHALL count 0..9 per frame.

Reset
REQ-027 RST=1 SHALL, on the next rising edge, force FSM to IDLE, busy=0, done=0, sram_rd_en=0, sram_addr=0, uart_tx_pin=1, and clear all counters, regardless of the current state.
REQ-028 Reset mid-frame SHALL truncate the frame, with no further bits driven; start held high during RST SHALL be ignored.
REQ-029 The first start after reset deassertion SHALL be honoured from the first cycle RST=0.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding, the header constant 0x53, and the UART frame length constant (10).
REQ-031 The byte serializer SHALL be a sub-module named uart_tx (ports clk, RST, tx_start, tx_data[7:0], tx_busy, tx_pin), reusable by other blocks and the counterpart of uart_rx.

Verification
REQ-032 CLKS_PER_BIT=4, DEPTH=4, SRAM = {0x44332211, 0x88776655, 0xCCBBAA99, 0x00FFEEDD}, pulse start -> decoded bytes 53 11 22 33 44 55 66 77 88 99 AA BB CC DD EE FF 00; done once, 17*40 cycles after the first start bit.
REQ-033 Same setup, check sram_rd_en -> exactly 4 pulses, addresses 0,1,2,3, each preceding the first bit of its word; no back-to-back frame gap.
REQ-034 start pulsed again mid-dump and on the done cycle -> no restart and no extra bytes; start after done -> second identical dump.
REQ-035 RST asserted during data bit 3 of byte 6 -> next cycle uart_tx_pin=1, busy=0; line idle until next start; next dump begins with 0x53.
REQ-036 Bit timing with CLKS_PER_BIT=5, word 0xA5A5A5A5 -> every bit exactly 5 cycles; pattern LSB-first 1,0,1,0,0,1,0,1; stop bit high.

Source files
------------

// File: rtl/mem_dump_tx_pkg.sv
// Shared definitions for the SRAM-to-UART dump block: FSM encoding,
// header byte, UART frame length and a byte-lane selector.
package mem_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_FETCH  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SEND   = 3'd4,
    ST_FINISH = 3'd5
  } dump_state_e;

  localparam logic [7:0]  HDR_BYTE   = 8'h53;
  localparam int unsigned FRAME_BITS = 32'd10;

  // Byte lane of a 32-bit word, lane 0 = bits [7:0]
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_dump_tx_uart_tx.sv
// 8N1 byte serializer. tx_busy falls in the final stop-bit cycle so a
// byte offered then starts on the very next cycle, giving gapless frames.
module uart_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active_r;
  logic [BW-1:0] baud_r;
  logic [3:0]    bit_r;
  logic [7:0]    data_r;
  logic          pin_r;
  logic          bit_end_s;
  logic          frame_end_s;
  logic          busy_s;
  logic          accept_s;

  // Decode end of bit / end of frame and the accept condition
  always_comb begin
    bit_end_s   = (baud_r == BW'(CLKS_PER_BIT - 1));
    frame_end_s = active_r && bit_end_s && (bit_r == 4'(FRAME_BITS - 32'd1));
    busy_s      = active_r && !frame_end_s;
    accept_s    = tx_start && !busy_s;
  end

  // Baud/bit counters and the registered line driver
  always_ff @(posedge clk) begin
    if (RST) begin
      active_r <= 1'b0;
      baud_r   <= '0;
      bit_r    <= 4'd0;
      data_r   <= 8'h00;
      pin_r    <= 1'b1;
    end else if (accept_s) begin
      active_r <= 1'b1;
      baud_r   <= '0;
      bit_r    <= 4'd0;
      data_r   <= tx_data;
      pin_r    <= 1'b0;
    end else if (active_r) begin
      if (bit_end_s) begin
        baud_r <= '0;
        if (bit_r == 4'(FRAME_BITS - 32'd1)) begin
          active_r <= 1'b0;
          bit_r    <= 4'd0;
          pin_r    <= 1'b1;
        end else begin
          bit_r <= bit_r + 4'd1;
          pin_r <= (bit_r == 4'(FRAME_BITS - 32'd2)) ? 1'b1 : data_r[bit_r[2:0]];
        end
      end else begin
        baud_r <= baud_r + BW'(1);
      end
    end
  end

  assign tx_busy = busy_s;
  assign tx_pin  = pin_r;

endmodule

// File: rtl/mem_dump_tx.sv
// Streams a header byte followed by every SRAM word (LSB byte first) out of
// a UART, one word fetched per four bytes sent.
module mem_dump_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int DEPTH        = 1024,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     sram_rd_en,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  input  logic [BITS-1:0]          sram_data,
  output logic                     uart_tx_pin
);

  localparam int AW = $clog2(DEPTH);

  dump_state_e state_r;
  dump_state_e next_state_s;
  logic [AW-1:0] word_idx_r;
  logic [1:0]    byte_idx_r;
  logic [31:0]   word_r;
  logic          busy_r;
  logic          done_r;
  logic          rd_en_r;
  logic          tx_start_s;
  logic [7:0]    tx_data_s;
  logic          tx_busy_s;
  logic          last_word_s;

  // Next-state and serializer request decode
  always_comb begin
    next_state_s = state_r;
    tx_start_s   = 1'b0;
    tx_data_s    = 8'h00;
    last_word_s  = (word_idx_r == AW'(DEPTH - 1));
    case (state_r)
      ST_IDLE: begin
        // done_r marks the completion cycle, in which start is still ignored
        if (start && !done_r) begin
          next_state_s = ST_HEADER;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        tx_data_s = HDR_BYTE;
        if (!tx_busy_s) begin
          tx_start_s   = 1'b1;
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_HEADER;
        end
      end
      ST_FETCH: next_state_s = ST_WAIT;
      ST_WAIT:  next_state_s = ST_SEND;
      ST_SEND: begin
        tx_data_s = byte_sel(word_r, byte_idx_r);
        if (!tx_busy_s) begin
          tx_start_s = 1'b1;
          if (byte_idx_r == 2'd3) begin
            next_state_s = last_word_s ? ST_FINISH : ST_FETCH;
          end else begin
            next_state_s = ST_SEND;
          end
        end else begin
          next_state_s = ST_SEND;
        end
      end
      ST_FINISH: begin
        if (!tx_busy_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FINISH;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, word/byte indices and registered outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      word_idx_r <= '0;
      byte_idx_r <= 2'd0;
      word_r     <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_en_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      done_r  <= (state_r == ST_FINISH) && (next_state_s == ST_IDLE);
      rd_en_r <= (next_state_s == ST_FETCH);
      if (next_state_s == ST_IDLE) begin
        word_idx_r <= '0;
      end else if ((state_r == ST_SEND) && tx_start_s && (byte_idx_r == 2'd3) && !last_word_s) begin
        word_idx_r <= word_idx_r + AW'(1);
      end
      if (state_r == ST_WAIT) begin
        word_r     <= sram_data[31:0];
        byte_idx_r <= 2'd0;
      end else if ((state_r == ST_SEND) && tx_start_s) begin
        byte_idx_r <= byte_idx_r + 2'd1;
      end
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .RST     (RST),
    .tx_start(tx_start_s),
    .tx_data (tx_data_s),
    .tx_busy (tx_busy_s),
    .tx_pin  (uart_tx_pin)
  );

  assign busy       = busy_r;
  assign done       = done_r;
  assign sram_rd_en = rd_en_r;
  assign sram_addr  = word_idx_r;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Self-checking bench: the expected line waveform is rebuilt from the SRAM
// contents and the 8N1 rules, then compared cycle by cycle.
module tb_mem_dump_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk;
  logic        RST;
  logic        start;
  logic        busy;
  logic        done;
  logic        sram_rd_en;
  logic [1:0]  sram_addr;
  logic [31:0] sram_data;
  logic        uart_tx_pin;
  logic [31:0] mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  mem_dump_tx #(.BITS(32), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .sram_rd_en (sram_rd_en),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .uart_tx_pin(uart_tx_pin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM: data valid the cycle after the strobe, junk otherwise
  always @(posedge clk) sram_data <= sram_rd_en ? mem[sram_addr] : $urandom();

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input bit release_rst, input bit inject);
    logic       pins[$];
    int         rd_cyc[$];
    int         rd_addr[$];
    int         done_cyc[$];
    logic [7:0] exp_b[$];
    logic       busy_c1, busy_done, ebit;
    logic [7:0] got_b;
    int         s, errs, zeros, limit, idx;
    bit         stop;
    limit     = (1 + 4 * DEPTH) * FRAME + 200;
    busy_c1   = 1'b0;
    busy_done = 1'b1;
    stop      = 1'b0;
    exp_b.push_back(8'h53);
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < 4; b++) exp_b.push_back(mem[w][8*b +: 8]);
    for (int c = 0; c < limit && !stop; c++) begin
      @(negedge clk);
      pins.push_back(uart_tx_pin);
      if (sram_rd_en) begin
        rd_cyc.push_back(c);
        rd_addr.push_back(int'(sram_addr));
      end
      if (done) begin
        done_cyc.push_back(c);
        busy_done = busy;
      end
      if (c == 1) busy_c1 = busy;
      if (c == 0 && release_rst) RST = 1'b0;
      start = (c == 0) || (inject && (done || c == 300));
      if (done_cyc.size() > 0 && c >= done_cyc[0] + 60) stop = 1'b1;
    end
    start = 1'b0;

    check_eq("done_count", done_cyc.size(), 1);
    check_eq("busy_rise", busy_c1, 1);
    check_eq("busy_at_done", busy_done, 0);
    check_eq("busy_end", busy, 0);
    check_eq("addr_idle", sram_addr, 0);
    s = -1;
    foreach (pins[i]) if (s < 0 && pins[i] == 1'b0) s = i;
    check_eq("first_start_bit", s, 2);
    if (s < 0) s = 2;
    for (int k = 0; k < exp_b.size(); k++) begin
      errs  = 0;
      got_b = 8'h00;
      for (int j = 0; j < 10; j++) begin
        ebit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[k][j-1];
        for (int t = 0; t < CPB; t++) begin
          idx = s + k * FRAME + j * CPB + t;
          if (idx >= pins.size() || pins[idx] !== ebit) errs++;
        end
        idx = s + k * FRAME + j * CPB + CPB / 2;
        if (j >= 1 && j <= 8 && idx < pins.size()) got_b[j-1] = pins[idx];
      end
      check_eq("frame_wave", errs, 0);
      check_eq("byte", got_b, exp_b[k]);
    end
    zeros = 0;
    for (int i = s + exp_b.size() * FRAME; i < pins.size(); i++) if (pins[i] !== 1'b1) zeros++;
    check_eq("idle_after", zeros, 0);
    if (done_cyc.size() > 0) check_eq("done_cycle", done_cyc[0] - s, exp_b.size() * FRAME);
    check_eq("rd_count", rd_cyc.size(), DEPTH);
    for (int k = 0; k < rd_cyc.size() && k < DEPTH; k++) begin
      check_eq("rd_addr", rd_addr[k], k);
      check_eq("rd_before_word", rd_cyc[k] < s + (1 + 4 * k) * FRAME, 1);
    end
  endtask

  initial begin
    logic pre_bit;
    int   bad_pin, bad_rd;
    RST   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", sram_rd_en, 0);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_pin", uart_tx_pin, 1);

    // start held during reset must not launch a dump
    start = 1'b1;
    repeat (3) @(negedge clk);
    RST   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("start_in_rst_busy", busy, 0);
    check_eq("start_in_rst_pin", uart_tx_pin, 1);

    // directed contents; start coincides with reset release
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    mem[2] = 32'hCCBBAA99;
    mem[3] = 32'h00FFEEDD;
    RST = 1'b1;
    @(negedge clk);
    run_dump(1'b1, 1'b0);

    // extra starts mid-dump and on the done cycle, then an identical repeat
    for (int w = 0; w < DEPTH; w++) mem[w] = $urandom();
    run_dump(1'b0, 1'b1);
    run_dump(1'b0, 1'b0);

    for (int w = 0; w < DEPTH; w++) mem[w] = 32'hA5A5A5A5;
    run_dump(1'b0, 1'b0);

    // reset during data bit 3 of byte 6 (start bit of the dump is cycle 2)
    for (int w = 0; w < DEPTH; w++) mem[w] = $urandom();
    pre_bit = 1'b0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (c == 259) begin
        pre_bit = uart_tx_pin;
        RST     = 1'b1;
      end
    end
    check_eq("pre_reset_bit", pre_bit, mem[1][11]);
    @(negedge clk);
    check_eq("midrst_pin", uart_tx_pin, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_addr", sram_addr, 0);
    RST     = 1'b0;
    bad_pin = 0;
    bad_rd  = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx_pin !== 1'b1) bad_pin++;
      if (sram_rd_en !== 1'b0) bad_rd++;
    end
    check_eq("midrst_line_idle", bad_pin, 0);
    check_eq("midrst_no_reads", bad_rd, 0);
    run_dump(1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < DEPTH; w++) mem[w] = $urandom();
      run_dump(1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
